// File: rtl/mips_muldiv_ctrl.sv
// rtl/mips_muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// One shift-add or restore-subtract step per cycle, then a sign fix-up cycle.
module mips_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [1:0]         op_r;
    logic               sa, sb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    // Operand capture: signed ops keep magnitudes plus sign bits.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[WIDTH-1];
    assign b_neg     = signed_op & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;

    // Multiply: high half accumulates, low half collects product bits shifted out.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_reg[0] ? a_reg : '0)};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: high half is the partial remainder, dividend bits enter from a_reg's MSB.
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_sub, rem_new;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, b_reg};
    assign rem_sub  = rem_sh[WIDTH-1:0] - b_reg;
    assign rem_new  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc[WIDTH-2:0], div_ge};

    // Fix-up. With a zero divisor the remainder ends up equal to |a|, so the
    // remainder sign correction restores the raw dividend for HI.
    logic               is_div, is_uns;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

    assign is_div   = op_r[1];
    assign is_uns   = op_r[0];
    assign prod_fix = (~is_uns & (sa ^ sb)) ? -acc : acc;
    assign q_fix    = (~is_uns & (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = (~is_uns & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? ((b_reg == '0) ? '1 : q_fix) : prod_fix[WIDTH-1:0];

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hi_we | lo_we | rd_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            op_r  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        op_r  <= op;
                        sa    <= a_neg;
                        sb    <= b_neg;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                    if (hi_we) hi <= wr_data;
                    if (lo_we) lo <= wr_data;
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc   <= div_next;
                        a_reg <= {a_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        acc   <= mul_next;
                        b_reg <= {1'b0, b_reg[WIDTH-1:1]};
                    end
                end
                FIXUP: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb/tb_mips_muldiv_ctrl.sv - scoreboard bench for mips_muldiv_ctrl
module tb_mips_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        hi_we, lo_we, rd_req;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    mips_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .rd_req(rd_req),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result and its cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with empty scoreboard at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(output int nbusy);
        nbusy = 0;
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   nb;
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        e.hi = ehi; e.lo = elo; e.cyc = cyc + 34;
        sb_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom_range(0, 3));
        rs_data = $urandom;
        rt_data = $urandom;
        wait_idle(nb);
        chk("busy_cycles", nb, 33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   nb;
        rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_done", done, 1'b0);

        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op(DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        run_op(DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

        // MTHI / MTLO in IDLE
        @(negedge clk); hi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'hABCD;
        #1 chk("mthi_idle", hi, 32'h1234);
        @(negedge clk); lo_we = 1'b0;
        #1 chk("mtlo_idle", lo, 32'hABCD);

        // Hazards while busy: rd_req held, a stray MTHI, and a second start
        @(negedge clk);
        start = 1'b1; op = DIVU; rs_data = 32'd100; rt_data = 32'd7; rd_req = 1'b1;
        e.hi = 32'd2; e.lo = 32'd14; e.cyc = cyc + 34;
        sb_q.push_back(e);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start   = (k == 10);
            op      = MULTU;
            rs_data = 32'd3;
            rt_data = 32'd3;
            hi_we   = (k == 5);
            wr_data = 32'h5A5A;
            #1;
            if (k <= 33) begin
                chk("hazard_busy", busy, 1'b1);
                chk("hazard_stall", stall, 1'b1);
                chk("hazard_hi_hold", hi, 32'h1234);
            end else begin
                chk("hazard_busy_fall", busy, 1'b0);
                chk("hazard_stall_fall", stall, 1'b0);
            end
        end
        start = 1'b0; hi_we = 1'b0; rd_req = 1'b0;

        // start together with MTHI in IDLE: both taken, result overwrites
        @(negedge clk);
        start = 1'b1; op = MULTU; rs_data = 32'd3; rt_data = 32'd4;
        hi_we = 1'b1; wr_data = 32'h5555;
        e.hi = 32'd0; e.lo = 32'd12; e.cyc = cyc + 34;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        #1 chk("start_mthi_hi", hi, 32'h5555);
        wait_idle(nb);
        chk("start_mthi_busy_cycles", nb, 33);

        // Asynchronous reset mid-operation; no done pulse may follow
        @(negedge clk);
        start = 1'b1; op = MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_ctrl.md
Name: mips_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV and DIVU over WIDTH iterations and services MTHI/MTLO writes.
- Raises a pipeline stall when any HI/LO-dependent instruction issues while an operation is in flight.
- Sits beside the ALU in the execute stage; the decoder supplies start/op/hi_we/lo_we/rd_req, and HI/LO feed the writeback mux.

Parameters:
WIDTH, 32, operand width; must be even and at least 4; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  launch op using rs_data/rt_data, sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  WIDTH  multiplicand / dividend (a)
rt_data  input  WIDTH  multiplier / divisor (b)
hi_we  input  1  MTHI request
lo_we  input  1  MTLO request
wr_data  input  WIDTH  MTHI/MTLO data
rd_req  input  1  MFHI/MFLO issued this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high when state != IDLE
stall  output  1  busy & (start | hi_we | lo_we | rd_req)
done  output  1  one-cycle pulse in the cycle after HI/LO update

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - On rst: state=IDLE, hi=0, lo=0, counter=0, internal accumulators=0, done=0, busy=0.
- States:
  - IDLE -> RUN on start. The edge that samples start latches |a|, |b|, op, sign(a), sign(b) and clears the accumulator and counter.
  - Unsigned ops latch raw operands; signed ops latch two's-complement magnitudes.
  - RUN: one shift-add (mult) or restore-subtract (div) step per cycle. Counter increments each cycle; after the step with counter=WIDTH-1, go to FIXUP.
  - FIXUP: apply sign correction, write hi/lo at the exiting edge, go to IDLE, assert done in the following cycle.
- Latency:
  - start sampled at edge N; RUN occupies edges N+1..N+WIDTH; FIXUP ends at edge N+WIDTH+1.
  - New hi/lo are visible after edge N+WIDTH+1 (33 edges for WIDTH=32).
  - busy is high for WIDTH+1 cycles.
- Arithmetic:
  - Mult result: hi:lo is the 2*WIDTH-bit product.
  - MULT negates the full 2*WIDTH product when sign(a)^sign(b).
  - Div result: lo=quotient, hi=remainder.
  - DIV negates the quotient when sign(a)^sign(b) and negates the remainder when sign(a) (truncating division).
  - DIV of most-negative by -1 gives lo=most-negative, hi=0, with no exception.
- Divide by zero (DIV or DIVU, b=0): hi=a (raw rs_data), lo=all ones, normal latency, no exception.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wr_data at the next edge.
  - While busy, they are ignored and stall holds; the pipeline re-presents them after busy falls.
  - In IDLE with start and hi_we/lo_we in the same cycle: both are accepted, and the op result later overwrites both registers.
- start while busy: ignored, stall asserted; no relaunch or corruption of the in-flight op.
- rd_req: no effect on state; only gates stall. hi/lo hold their old values until the FIXUP exit edge.
- Reset mid-operation: immediate abort to reset values; no done pulse.
- op/rs_data/rt_data changes after the launch edge have no effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 after edge N+33; busy high 33 cycles; done pulses once.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=5 b=0 -> hi=5 lo=0xFFFFFFFF at normal latency; DIV a=0xFFFFFFF0 b=0 -> hi=0xFFFFFFF0 lo=0xFFFFFFFF.
- Hazards during an op:
  - rd_req=1 -> stall=1 every busy cycle, then 0 in the cycle busy falls.
  - hi_we with wr_data=0x1234 while busy -> hi unchanged.
  - hi_we with wr_data=0x1234 in IDLE -> hi=0x1234 next cycle.
  - start during busy -> result equals the first op only.
- Assert rst asynchronously mid-edge at RUN cycle 10 -> hi=lo=0, busy=0 immediately, no done pulse; a new MULTU 3*4 afterwards gives hi=0 lo=12.
